// File: rtl/lsu_align_pkg.sv
// lsu_pkg: shared constants for the load/store alignment unit.
// FSM state codes, RISC-V load/store funct3 values and dmem lane codes.
package lsu_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_SPLIT = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [3:0] LANE_NONE = 4'b0000;
    localparam logic [3:0] LANE_HLO  = 4'b0011;
    localparam logic [3:0] LANE_HHI  = 4'b1100;
    localparam logic [3:0] LANE_W    = 4'b1111;
    localparam logic [4:0] RMEM_NONE = 5'b00000;

    function automatic logic [3:0] byte_lane(input logic [1:0] off);
        return 4'b0001 << off;
    endfunction

endpackage

// File: rtl/lsu_align_if.sv
// lsu_align_if: request/response handshake plus dmem access signals.
// master = execute stage side, slave = lsu_align.
interface lsu_align_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_load;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;
    logic [3:0]        wmem;
    logic [4:0]        rmem;
    logic [31:0]       mem_addr;
    logic [31:0]       store_data;
    logic [31:0]       load_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_fault;

    modport master (
        output req_valid, req_load, req_store, req_funct3,
        output req_addr, req_wdata, req_rd, rsp_ready, load_data,
        input  req_ready, wmem, rmem, mem_addr, store_data,
        input  rsp_valid, rsp_data, rsp_rd, rsp_fault
    );

    modport slave (
        input  req_valid, req_load, req_store, req_funct3,
        input  req_addr, req_wdata, req_rd, rsp_ready, load_data,
        output req_ready, wmem, rmem, mem_addr, store_data,
        output rsp_valid, rsp_data, rsp_rd, rsp_fault
    );
endinterface

// File: rtl/lsu_align_lane_decode.sv
// lsu_lane_decode: funct3/offset/direction to byte-lane code, sign,
// access size, misaligned flag and illegal flag.
module lsu_lane_decode
    import lsu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] off,
    input  logic       load,
    input  logic       store,
    output logic [3:0] lanes,
    output logic       sign,
    output logic [2:0] size,
    output logic       misal,
    output logic       illegal
);

    // Unsigned byte/half codes only exist for loads.
    always_comb begin
        lanes   = LANE_NONE;
        sign    = 1'b0;
        size    = 3'd0;
        misal   = 1'b0;
        illegal = (load == store);
        unique case (1'b1)
            (funct3 == F3_LB) || (load && funct3 == F3_LBU): begin
                size  = 3'd1;
                lanes = byte_lane(off);
                sign  = load && (funct3 == F3_LB);
            end
            (funct3 == F3_LH) || (load && funct3 == F3_LHU): begin
                size  = 3'd2;
                lanes = off[1] ? LANE_HHI : LANE_HLO;
                misal = off[0];
                sign  = load && (funct3 == F3_LH);
            end
            (funct3 == F3_LW): begin
                size  = 3'd4;
                lanes = LANE_W;
                misal = (off != 2'd0);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_align.sv
// lsu_align: aligns execute-stage loads/stores onto dmem's word/lane ports.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned loads into byte reads.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input logic        clk,
    input logic        rst,
    lsu_align_if.slave bus
);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        f3_q;
    logic              ld_q;
    logic              st_q;
    logic [31:0]       wd_q;
    logic [3:0]        lanes_q;
    logic              sign_q;
    logic [4:0]        rd_q;
    logic              fault_q;
    logic [31:0]       data_q;

    logic [3:0]        dec_lanes;
    logic              dec_sign;
    logic [2:0]        dec_size;
    logic              dec_misal;
    logic              dec_illegal;
    logic              fault_d;
    logic [31:0]       sh;
    logic [31:0]       ld_ext;

    lsu_lane_decode u_dec (
        .funct3  (bus.req_funct3),
        .off     (bus.req_addr[1:0]),
        .load    (bus.req_load),
        .store   (bus.req_store),
        .lanes   (dec_lanes),
        .sign    (dec_sign),
        .size    (dec_size),
        .misal   (dec_misal),
        .illegal (dec_illegal)
    );

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [2:0]        size_q;
    logic [1:0]        cnt;
    logic [ADDR_W-1:0] sa;
    logic [7:0]        sbyte;
    logic              last;

    assign fault_d = dec_illegal | (dec_misal & bus.req_store);
    assign sa      = addr_q + ADDR_W'(cnt);
    assign sbyte   = 8'(bus.load_data >> {sa[1:0], 3'b000});
    assign last    = (({1'b0, cnt}) + 3'd1) == size_q;
`else
    logic unused_size;

    assign fault_d     = dec_illegal | dec_misal;
    assign unused_size = ^dec_size;
`endif

    assign sh = bus.load_data >> {addr_q[1:0], 3'b000};

    // Extend the addressed byte/half/word of the raw dmem word.
    always_comb begin
        ld_ext = sh;
        unique case (f3_q)
            2'd0:    ld_ext = {{24{sign_q & sh[7]}}, sh[7:0]};
            2'd1:    ld_ext = {{16{sign_q & sh[15]}}, sh[15:0]};
            default: ld_ext = sh;
        endcase
    end

    // dmem strobes only in ACC/SPLIT; reset drops state so wmem clears at once.
    always_comb begin
        bus.wmem       = LANE_NONE;
        bus.rmem       = RMEM_NONE;
        bus.mem_addr   = '0;
        bus.store_data = '0;
        if (state == ST_ACC) begin
            bus.mem_addr = 32'(addr_q >> 2);
            if (st_q) begin
                bus.wmem       = lanes_q;
                bus.store_data = wd_q;
            end else begin
                bus.rmem = {sign_q, lanes_q};
            end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state == ST_SPLIT) begin
            bus.mem_addr = 32'(sa >> 2);
            bus.rmem     = {1'b0, byte_lane(sa[1:0])};
        end
`endif
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_rd    = rd_q;
    assign bus.rsp_fault = fault_q;

    // Request latch, access sequencing and response hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            ld_q    <= 1'b0;
            st_q    <= 1'b0;
            wd_q    <= '0;
            lanes_q <= '0;
            sign_q  <= 1'b0;
            rd_q    <= '0;
            fault_q <= 1'b0;
            data_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            size_q  <= '0;
            cnt     <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: if (bus.req_valid) begin
                    addr_q  <= bus.req_addr;
                    f3_q    <= bus.req_funct3[1:0];
                    ld_q    <= bus.req_load;
                    st_q    <= bus.req_store;
                    wd_q    <= bus.req_wdata;
                    lanes_q <= dec_lanes;
                    sign_q  <= dec_sign;
                    rd_q    <= bus.req_rd;
                    fault_q <= fault_d;
                    data_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    size_q  <= dec_size;
                    cnt     <= '0;
                    if (fault_d)        state <= ST_RESP;
                    else if (dec_misal) state <= ST_SPLIT;
                    else                state <= ST_ACC;
`else
                    state   <= fault_d ? ST_RESP : ST_ACC;
`endif
                end
                ST_ACC: begin
                    if (ld_q) data_q <= ld_ext;
                    state <= ST_RESP;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                ST_SPLIT: begin
                    data_q[{cnt, 3'b000} +: 8] <= sbyte;
                    cnt <= cnt + 2'd1;
                    if (last) begin
                        if (sign_q) data_q[31:16] <= {16{sbyte[7]}};
                        state <= ST_RESP;
                    end
                end
`endif
                ST_RESP: if (bus.rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_align.sv
// tb_lsu_align: directed vectors for lsu_align with hand-computed results.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_lsu_align;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   wr_cnt = 0;
    int   w0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    lsu_align_if #(.ADDR_W(32)) bus ();

    lsu_align #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.load_data = mem[bus.mem_addr[7:0]];

    // Count every edge at which dmem would commit a write.
    always @(posedge clk) if (bus.wmem != 4'b0000) wr_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_rd     = rd;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] sp_wa [4] = '{32'h40, 32'h40, 32'h40, 32'h41};
    logic [31:0] sp_rm [4] = '{32'h02, 32'h04, 32'h08, 32'h01};
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        bus.req_valid  = 1'b0;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = '0;
        bus.rsp_ready  = 1'b1;

        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_wmem", bus.wmem, 0);
        chk("rst_rmem", bus.rmem, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        rst = 1'b0;

        // SB 0x106
        w0 = wr_cnt;
        issue(1'b0, 1'b1, 3'd0, 32'h106, 32'h123456AB, 5'd1);
        chk("sb_wmem", bus.wmem, 32'b0100);
        chk("sb_addr", bus.mem_addr, 32'h41);
        chk("sb_sdata", bus.store_data, 32'h123456AB);
        chk("sb_busy", bus.req_ready, 0);
        @(negedge clk);
        chk("sb_valid", bus.rsp_valid, 1);
        chk("sb_fault", bus.rsp_fault, 0);
        chk("sb_data", bus.rsp_data, 0);
        chk("sb_rd", bus.rsp_rd, 1);
        chk("sb_wrcnt", 32'(wr_cnt - w0), 1);
        @(negedge clk);
        chk("sb_idle", bus.req_ready, 1);

        // LB 0x103
        mem[8'h40] = 32'h80FFFFFF;
        issue(1'b1, 1'b0, 3'd0, 32'h103, 32'h0, 5'd2);
        chk("lb_rmem", bus.rmem, 32'b11000);
        chk("lb_addr", bus.mem_addr, 32'h40);
        chk("lb_wmem", bus.wmem, 0);
        @(negedge clk);
        chk("lb_valid", bus.rsp_valid, 1);
        chk("lb_data", bus.rsp_data, 32'hFFFFFF80);
        chk("lb_rd", bus.rsp_rd, 2);
        @(negedge clk);

        // LHU 0x102 with response back-pressure
        mem[8'h40] = 32'hBEEF1234;
        bus.rsp_ready = 1'b0;
        issue(1'b1, 1'b0, 3'd5, 32'h102, 32'h0, 5'd3);
        chk("lhu_rmem", bus.rmem, 32'b01100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lhu_valid", bus.rsp_valid, 1);
            chk("lhu_data", bus.rsp_data, 32'h0000BEEF);
            chk("lhu_busy", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("lhu_done", bus.rsp_valid, 0);
        chk("lhu_idle", bus.req_ready, 1);

        // LW 0x101 misaligned
        mem[8'h40] = 32'h44332211;
        mem[8'h41] = 32'h88776655;
        issue(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 5'd4);
`ifdef LSU_MISALIGN_SPLIT_EN
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("split_addr", bus.mem_addr, sp_wa[i]);
            chk("split_rmem", bus.rmem, sp_rm[i]);
        end
        @(negedge clk);
        chk("split_valid", bus.rsp_valid, 1);
        chk("split_data", bus.rsp_data, 32'h55443322);
        chk("split_fault", bus.rsp_fault, 0);
`else
        chk("lwmis_valid", bus.rsp_valid, 1);
        chk("lwmis_fault", bus.rsp_fault, 1);
        chk("lwmis_rmem", bus.rmem, 0);
        chk("lwmis_data", bus.rsp_data, 0);
`endif
        @(negedge clk);

        // SH 0x103 misaligned store
        w0 = wr_cnt;
        issue(1'b0, 1'b1, 3'd1, 32'h103, 32'h0000FFFF, 5'd6);
        chk("sh_valid", bus.rsp_valid, 1);
        chk("sh_fault", bus.rsp_fault, 1);
        chk("sh_wmem", bus.wmem, 0);
        @(negedge clk);
        chk("sh_nowrite", 32'(wr_cnt - w0), 0);

        // load and store both set
        issue(1'b1, 1'b1, 3'd2, 32'h100, 32'h0, 5'd7);
        chk("ldst_fault", bus.rsp_fault, 1);
        chk("ldst_valid", bus.rsp_valid, 1);
        @(negedge clk);

        // load with funct3 = 3
        issue(1'b1, 1'b0, 3'd3, 32'h100, 32'h0, 5'd7);
        chk("f3ill_fault", bus.rsp_fault, 1);
        @(negedge clk);

        // reset during an aligned SW access
        w0 = wr_cnt;
        issue(1'b0, 1'b1, 3'd2, 32'h108, 32'hDEADBEEF, 5'd8);
        chk("sw_wmem", bus.wmem, 32'b1111);
        rst = 1'b1;
        #1;
        chk("swrst_wmem", bus.wmem, 0);
        chk("swrst_ready", bus.req_ready, 1);
        chk("swrst_valid", bus.rsp_valid, 0);
        chk("swrst_sdata", bus.store_data, 0);
        chk("swrst_rd", bus.rsp_rd, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("swrst_nowrite", 32'(wr_cnt - w0), 0);
        @(negedge clk);
        chk("swrst_novalid", bus.rsp_valid, 0);

`ifdef LSU_MISALIGN_SPLIT_EN
        // reset during the second byte of a split load
        issue(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 5'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("sprst_ready", bus.req_ready, 1);
        chk("sprst_rmem", bus.rmem, 0);
        chk("sprst_addr", bus.mem_addr, 0);
        chk("sprst_data", bus.rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("sprst_novalid", bus.rsp_valid, 0);
        chk("sprst_idle", bus.req_ready, 1);
`endif

        // aligned LW after reset
        issue(1'b1, 1'b0, 3'd2, 32'h100, 32'h0, 5'd9);
        chk("lw_rmem", bus.rmem, 32'b01111);
        chk("lw_addr", bus.mem_addr, 32'h40);
        @(negedge clk);
        chk("lw_valid", bus.rsp_valid, 1);
        chk("lw_data", bus.rsp_data, 32'h44332211);
        chk("lw_rd", bus.rsp_rd, 9);
        chk("lw_fault", bus.rsp_fault, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
